// File: rtl/puf_challenge_ctrl.sv
`timescale 1ns/1ps
// puf_challenge_ctrl: runs REPEATS clear/excite/settle/sample evaluations of the PUF datapath
// per challenge and returns the majority-voted response bit over a valid/ready handshake.
module puf_challenge_ctrl #(
  parameter int N       = 128,
  parameter int PULSES  = 64,
  parameter int HALF    = 2,
  parameter int SETTLE  = 8,
  parameter int REPEATS = 3,
  parameter int VW      = $clog2(REPEATS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_chal,
  output logic [N-1:0]  puf_sel,
  output logic          puf_in,
  output logic          puf_rst,
  input  logic          puf_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_bit,
  output logic [VW-1:0] rsp_votes,
  output logic          busy
);
  localparam int EXC = 2 * HALF * PULSES;
  localparam int CW  = $clog2(EXC > SETTLE ? EXC : SETTLE) + 1;
  localparam int HW  = $clog2(HALF + 1);
  localparam int RW  = $clog2(REPEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_EXCITE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [HW-1:0] r_half, w_half_n;
  logic [RW-1:0] r_rep, w_rep_n;
  logic [VW-1:0] r_votes, w_votes_n;
  logic [N-1:0]  r_sel, w_sel_n;
  logic          r_in, w_in_n;
  logic          r_rst, w_rst_n;
  logic [1:0]    r_sync;
  logic          w_half_end;
  logic          w_last_rep;

  assign w_half_end = r_half == HW'(HALF - 1);
  assign w_last_rep = r_rep == RW'(REPEATS - 1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_rep   <= '0;
      r_votes <= '0;
      r_sel   <= '0;
      r_in    <= 1'b0;
      r_rst   <= 1'b1;
      r_sync  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_half  <= w_half_n;
      r_rep   <= w_rep_n;
      r_votes <= w_votes_n;
      r_sel   <= w_sel_n;
      r_in    <= w_in_n;
      r_rst   <= w_rst_n;
      r_sync  <= {r_sync[0], puf_out};
    end

  // puf_in/puf_rst are registered, so they are derived from the next state and next counters
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_half_n  = '0;
    w_in_n    = 1'b0;
    w_rep_n   = r_rep;
    w_votes_n = r_votes;
    w_sel_n   = r_sel;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (req_valid) begin
          w_state_n = S_CLEAR;
          w_sel_n   = req_chal;
          w_rep_n   = '0;
          w_votes_n = '0;
        end
      end
      S_CLEAR:
        if (r_cnt == CW'(1)) begin
          w_state_n = S_EXCITE;
          w_cnt_n   = '0;
        end
      S_EXCITE: begin
        w_half_n = w_half_end ? '0 : r_half + 1'b1;
        w_in_n   = w_half_end ? ~r_in : r_in;
        if (r_cnt == CW'(EXC - 1)) begin
          w_state_n = S_SETTLE;
          w_cnt_n   = '0;
          w_in_n    = 1'b0;
        end
      end
      S_SETTLE:
        if (r_cnt == CW'(SETTLE - 1)) begin
          w_state_n = S_SAMPLE;
          w_cnt_n   = '0;
        end
      S_SAMPLE: begin
        w_cnt_n   = '0;
        w_votes_n = (r_votes == VW'(REPEATS)) ? r_votes : r_votes + VW'(r_sync[1]);
        w_state_n = w_last_rep ? S_DONE : S_CLEAR;
        w_rep_n   = w_last_rep ? r_rep : r_rep + 1'b1;
      end
      S_DONE: begin
        w_cnt_n = '0;
        if (rsp_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_rst_n = w_state_n inside {S_IDLE, S_CLEAR, S_DONE};
  end

  assign req_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign rsp_valid = r_state == S_DONE;
  assign rsp_bit   = r_votes > VW'(REPEATS / 2);
  assign rsp_votes = r_votes;
  assign puf_sel   = r_sel;
  assign puf_in    = r_in;
  assign puf_rst   = r_rst;
endmodule

// File: tb/tb_puf_challenge_ctrl.sv
`timescale 1ns/1ps
// tb_puf_challenge_ctrl: randomized checks of the PUF challenge sequencer against a timing/vote model
// derived from the evaluation schedule (default instance) plus a short-pulse instance for waveform shape.
module tb_puf_challenge_ctrl;
  localparam int N = 128, PULSES = 64, HALF = 2, SETTLE = 8, REP = 3;
  localparam int E = 2 + 2 * HALF * PULSES + SETTLE + 1;
  localparam int SN = 8, SP = 4, SH = 1, SS = 3, SR = 3;
  localparam int ES = 2 + 2 * SH * SP + SS + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0, puf_out = 1'b0;
  logic [N-1:0] req_chal = '0;
  logic req_ready, puf_in, puf_rst, rsp_valid, rsp_bit, busy;
  logic [N-1:0] puf_sel;
  logic [1:0] rsp_votes;

  logic s_req_valid = 1'b0, s_rsp_ready = 1'b1, s_puf_out = 1'b0;
  logic [SN-1:0] s_req_chal = '0;
  logic s_req_ready, s_puf_in, s_puf_rst, s_rsp_valid, s_rsp_bit, s_busy;
  logic [SN-1:0] s_puf_sel;
  logic [1:0] s_rsp_votes;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  puf_challenge_ctrl #(.N(N), .PULSES(PULSES), .HALF(HALF), .SETTLE(SETTLE), .REPEATS(REP)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_chal(req_chal),
    .puf_sel(puf_sel), .puf_in(puf_in), .puf_rst(puf_rst), .puf_out(puf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_votes(rsp_votes), .busy(busy));

  puf_challenge_ctrl #(.N(SN), .PULSES(SP), .HALF(SH), .SETTLE(SS), .REPEATS(SR)) u_small (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_chal(s_req_chal),
    .puf_sel(s_puf_sel), .puf_in(s_puf_in), .puf_rst(s_puf_rst), .puf_out(s_puf_out),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_bit(s_rsp_bit), .rsp_votes(s_rsp_votes), .busy(s_busy));

  function automatic logic [N-1:0] rand_chal();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accepts chal in cycle 0, drives puf_out=pat[k] for evaluation k, returns at the first rsp_valid cycle.
  task automatic run_txn(input logic [N-1:0] chal, input logic [2:0] pat, output int lat,
                         output logic [N-1:0] sel1, output bit sel_ok);
    lat = -1;
    sel_ok = 1'b1;
    sel1 = '0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_chal = chal;
    puf_out = pat[0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_chal = rand_chal();
    for (int c = 1; c <= REP * E + 20; c++) begin
      if ((c - 1) % E == 0 && (c - 1) / E < REP) puf_out = pat[(c - 1) / E];
      @(negedge clk);
      if (c == 1) sel1 = puf_sel;
      if (puf_sel !== chal) sel_ok = 1'b0;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (puf_sel !== '0) begin n_fail++; $display("FAIL rst_puf_sel: got %h want 0", puf_sel); end
    n_checks++; if (puf_in !== 1'b0) begin n_fail++; $display("FAIL rst_puf_in: got %b want 0", puf_in); end
    n_checks++; if (puf_rst !== 1'b1) begin n_fail++; $display("FAIL rst_puf_rst: got %b want 1", puf_rst); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_bit !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_bit: got %b want 0", rsp_bit); end
    n_checks++; if (rsp_votes !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_votes: got %0d want 0", rsp_votes); end
    n_checks++;
    if ({s_req_ready, s_busy, s_puf_in, s_puf_rst, s_rsp_valid, s_rsp_bit, s_rsp_votes, s_puf_sel} !== {6'b100100, 2'd0, 8'd0}) begin
      n_fail++; $display("FAIL rst_small: got %b/%b/%b/%b/%b/%b/%0d/%h want 1/0/0/1/0/0/0/00",
        s_req_ready, s_busy, s_puf_in, s_puf_rst, s_rsp_valid, s_rsp_bit, s_rsp_votes, s_puf_sel);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] chal, sel1;
    int lat;
    bit ok;
    chal = {16{8'hA5}};
    rsp_ready = 1'b1;
    run_txn(chal, 3'b111, lat, sel1, ok);
    n_checks++; if (lat !== 1 + REP * E) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, 1 + REP * E); end
    n_checks++; if (sel1 !== chal) begin n_fail++; $display("FAIL basic_sel_cycle1: got %h want %h", sel1, chal); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_sel_stable: got %b want 1", ok); end
    n_checks++; if (rsp_bit !== 1'b1) begin n_fail++; $display("FAIL basic_bit: got %b want 1", rsp_bit); end
    n_checks++; if (rsp_votes !== 2'd3) begin n_fail++; $display("FAIL basic_votes: got %0d want 3", rsp_votes); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_done: got %b want 0", req_ready); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_return: got %b want 1", req_ready); end
    n_checks++; if (rsp_votes !== 2'd3) begin n_fail++; $display("FAIL basic_votes_hold_idle: got %0d want 3", rsp_votes); end
  endtask

  task automatic test_mixed_votes();
    logic [2:0] pats [6];
    logic [N-1:0] chal, sel1;
    int lat, ev;
    bit ok, eb;
    pats[0] = 3'b101;
    pats[1] = 3'b100;
    for (int i = 2; i < 6; i++) pats[i] = 3'($urandom_range(0, 7));
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chal = rand_chal();
      ev = $countones(pats[i]);
      eb = ev > REP / 2;
      run_txn(chal, pats[i], lat, sel1, ok);
      n_checks++; if (lat !== 1 + REP * E) begin n_fail++; $display("FAIL mixed_latency[%0d]: got %0d want %0d", i, lat, 1 + REP * E); end
      n_checks++; if (rsp_votes !== 2'(ev)) begin n_fail++; $display("FAIL mixed_votes[%0d] pat=%b: got %0d want %0d", i, pats[i], rsp_votes, ev); end
      n_checks++; if (rsp_bit !== eb) begin n_fail++; $display("FAIL mixed_bit[%0d] pat=%b: got %b want %b", i, pats[i], rsp_bit, eb); end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mixed_sel_stable[%0d]: got %b want 1", i, ok); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mixed_valid_drop[%0d]: got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] chal, sel1;
    logic [2:0] pat;
    int lat, ev;
    bit ok, eb;
    chal = rand_chal();
    pat = 3'($urandom_range(0, 7));
    ev = $countones(pat);
    eb = ev > REP / 2;
    rsp_ready = 1'b0;
    run_txn(chal, pat, lat, sel1, ok);
    n_checks++; if (lat !== 1 + REP * E) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, 1 + REP * E); end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_chal = rand_chal();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); end
      n_checks++; if (rsp_bit !== eb) begin n_fail++; $display("FAIL bp_bit[%0d]: got %b want %b", i, rsp_bit, eb); end
      n_checks++; if (rsp_votes !== 2'(ev)) begin n_fail++; $display("FAIL bp_votes[%0d]: got %0d want %0d", i, rsp_votes, ev); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
      n_checks++; if (puf_sel !== chal) begin n_fail++; $display("FAIL bp_sel[%0d]: got %h want %h", i, puf_sel, chal); end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_ready: got %b want 1", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_to_idle: got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    n_checks++; if (puf_sel !== chal) begin n_fail++; $display("FAIL bp_sel_after: got %h want %h", puf_sel, chal); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] chal, sel1;
    int lat;
    bit ok;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_chal = rand_chal();
    puf_out = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // land inside EXCITE of the third evaluation, after two votes of 1 were collected
    repeat (2 * E + 100 - 1) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || puf_rst !== 1'b0) begin n_fail++; $display("FAIL rm_pre_state: got busy=%b rst=%b want 1/0", busy, puf_rst); end
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_ready_busy: got %b/%b want 1/0", req_ready, busy); end
    n_checks++; if (puf_in !== 1'b0 || puf_rst !== 1'b1) begin n_fail++; $display("FAIL rm_puf_io: got in=%b rst=%b want 0/1", puf_in, puf_rst); end
    n_checks++; if (puf_sel !== '0) begin n_fail++; $display("FAIL rm_sel: got %h want 0", puf_sel); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_bit !== 1'b0 || rsp_votes !== 2'd0) begin n_fail++; $display("FAIL rm_rsp: got %b/%b/%0d want 0/0/0", rsp_valid, rsp_bit, rsp_votes); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b want 1", req_ready); end
    chal = rand_chal();
    run_txn(chal, 3'b000, lat, sel1, ok);
    n_checks++; if (lat !== 1 + REP * E) begin n_fail++; $display("FAIL rm_latency: got %0d want %0d", lat, 1 + REP * E); end
    n_checks++; if (rsp_votes !== 2'd0 || rsp_bit !== 1'b0) begin n_fail++; $display("FAIL rm_fresh_votes: got %0d/%b want 0/0", rsp_votes, rsp_bit); end
    @(negedge clk);
  endtask

  task automatic test_pulse_shape();
    int edges, p, k;
    bit prev, ein, erst;
    s_rsp_ready = 1'b1;
    @(posedge clk); #1;
    s_req_valid = 1'b1;
    s_req_chal = 8'h3C;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    s_req_chal = 8'hFF;
    edges = 0;
    prev = 1'b0;
    for (int c = 1; c <= SR * ES + 1; c++) begin
      @(negedge clk);
      p = (c - 1) % ES;
      k = (c - 1) / ES;
      if (k >= SR) begin erst = 1'b1; ein = 1'b0; end
      else if (p < 2) begin erst = 1'b1; ein = 1'b0; end
      else if (p < 2 + 2 * SH * SP) begin erst = 1'b0; ein = ((p - 2) / SH) % 2 == 1; end
      else begin erst = 1'b0; ein = 1'b0; end
      n_checks++; if (s_puf_in !== ein) begin n_fail++; $display("FAIL pulse_in c=%0d: got %b want %b", c, s_puf_in, ein); end
      n_checks++; if (s_puf_rst !== erst) begin n_fail++; $display("FAIL pulse_rst c=%0d: got %b want %b", c, s_puf_rst, erst); end
      n_checks++; if (s_rsp_valid !== (k >= SR)) begin n_fail++; $display("FAIL pulse_valid c=%0d: got %b want %b", c, s_rsp_valid, k >= SR); end
      n_checks++; if (s_puf_sel !== 8'h3C) begin n_fail++; $display("FAIL pulse_sel c=%0d: got %h want 3c", c, s_puf_sel); end
      if (s_puf_in === 1'b1 && !prev) edges++;
      prev = s_puf_in === 1'b1;
      if (p == ES - 1 && k < SR) begin
        n_checks++; if (edges !== SP) begin n_fail++; $display("FAIL pulse_edges eval=%0d: got %0d want %0d", k, edges, SP); end
        edges = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] c1, c2, prev_sel;
    int a0, a1;
    int chg[$];
    bit seen;
    rsp_ready = 1'b1;
    puf_out = 1'b1;
    prev_sel = puf_sel;
    c1 = ~puf_sel;
    c2 = rand_chal();
    if (c2 == c1) c2 = ~c1;
    a0 = -1;
    a1 = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_chal = c1;
    for (int c = 0; c < 2 * (REP * E + 2) + 20; c++) begin
      @(negedge clk);
      if (puf_sel !== prev_sel) begin chg.push_back(c); prev_sel = puf_sel; end
      if (req_valid && req_ready) begin
        if (a0 < 0) a0 = c; else a1 = c;
      end
      if (a1 >= 0 && c > a1 + 2) break;
      @(posedge clk); #1;
      if (a0 >= 0) req_chal = c2;
      if (a1 >= 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    n_checks++; if (a0 !== 0) begin n_fail++; $display("FAIL b2b_first_accept: got %0d want 0", a0); end
    n_checks++; if (a1 - a0 !== REP * E + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", a1 - a0, REP * E + 2); end
    n_checks++;
    if (chg.size() != 2 || chg[0] != a0 + 1 || chg[1] != a1 + 1) begin
      n_fail++; $display("FAIL b2b_sel_changes: got n=%0d first=%0d second=%0d want 2/%0d/%0d",
        chg.size(), chg.size() > 0 ? chg[0] : -1, chg.size() > 1 ? chg[1] : -1, a0 + 1, a1 + 1);
    end
    n_checks++; if (puf_sel !== c2) begin n_fail++; $display("FAIL b2b_sel_value: got %h want %h", puf_sel, c2); end
    seen = 1'b0;
    for (int c = 0; c < REP * E + 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1 || rsp_votes !== 2'd3) begin n_fail++; $display("FAIL b2b_second_rsp: got seen=%b votes=%0d want 1/3", seen, rsp_votes); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 1", req_ready); end
  endtask

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_mixed_votes();
    test_backpressure();
    test_reset_mid();
    test_pulse_shape();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
